// File: rtl/bch_serial_encoder_pkg.sv
// Shared constants for the bit-serial BCH encoder slice.
// Holds the default code (7,4) with g(x) = x^3 + x + 1 and the FSM state encodings.
// The decoder side of the channel uses the same defaults and state encodings.
package bch_serial_encoder_pkg;

    localparam int unsigned BCH_N_DEFAULT       = 7;
    localparam int unsigned BCH_K_DEFAULT       = 4;
    localparam int unsigned BCH_M_DEFAULT       = BCH_N_DEFAULT - BCH_K_DEFAULT;
    localparam logic [3:0]  BCH_POLYNOM_DEFAULT = 4'b1011;

    localparam logic [0:0] S_DATA   = 1'b0;
    localparam logic [0:0] S_PARITY = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// M-bit Galois-form divider by g(x), used to form BCH parity bit-serially.
// Ports:
//   CLK        in  clock, rising edge
//   RESET      in  synchronous active-high reset, clears the register
//   clr        in  clear the register (takes priority over en)
//   en         in  advance the register this cycle
//   shift_out  in  1: plain left shift (parity readout), 0: divide step with shift_in
//   shift_in   in  next message bit for the divide step
//   parity_msb out current register MSB, i.e. the next parity bit to emit
module bch_parity_lfsr #(
    parameter int unsigned M    = 3,
    parameter logic [M:0]  POLY = 4'b1011
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    input  logic shift_out,
    input  logic shift_in,
    output logic parity_msb
);

    logic [M-1:0] r_q, r_d;
    logic         fb;

    assign fb         = shift_in ^ r_q[M-1];
    assign parity_msb = r_q[M-1];

    always_comb begin
        r_d = r_q;
        if (clr) begin
            r_d = '0;
        end else if (en) begin
            if (shift_out) begin
                r_d = r_q << 1;
            end else begin
                r_d[0] = fb & POLY[0];
                for (int i = 1; i < int'(M); i++) begin
                    r_d[i] = r_q[i-1] ^ (fb & POLY[i]);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/bch_serial_encoder.sv
// Bit-serial systematic BCH encoder. Each codeword: ENC_K info bits passed through,
// then ENC_N-ENC_K parity bits, MSB first, back-to-back.
// Optional feature macro: BCH_ENC_SOF_EN adds DATA_OUT_SOF (start-of-codeword flag).
// Ports:
//   CLK            in  clock, rising edge
//   RESET          in  synchronous active-high reset
//   DATA_IN        in  info bit, taken when DATA_IN_VALID && DATA_IN_READY
//   DATA_IN_VALID  in  DATA_IN is valid
//   DATA_IN_READY  out encoder can take an info bit (low while parity is emitted)
//   DATA_OUT       out registered coded bit
//   DATA_OUT_VALID out DATA_OUT valid this cycle (no backpressure)
//   DATA_OUT_SOF   out (BCH_ENC_SOF_EN only) high with data bit 0 of each codeword
module bch_serial_encoder
    import bch_serial_encoder_pkg::*;
#(
    parameter int unsigned              ENC_N           = BCH_N_DEFAULT,
    parameter int unsigned              ENC_K           = BCH_K_DEFAULT,
    parameter logic [ENC_N-ENC_K:0]     ENC_BCH_POLYNOM = BCH_POLYNOM_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic DATA_IN,
    input  logic DATA_IN_VALID,
    output logic DATA_IN_READY,
    output logic DATA_OUT,
    output logic DATA_OUT_VALID
`ifdef BCH_ENC_SOF_EN
    ,
    output logic DATA_OUT_SOF
`endif
);

    localparam int unsigned M  = ENC_N - ENC_K;
    localparam int unsigned CW = $clog2(max_u(ENC_K, M)) + 1;
    localparam logic [CW-1:0] K_LAST = CW'(ENC_K - 1);
    localparam logic [CW-1:0] M_LAST = CW'(M - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          dval_q, dval_d;
    logic          accept;
    logic          in_parity;
    logic          parity_msb;

    assign in_parity     = (state_q == S_PARITY);
    // Gated by RESET so no bit is ever consumed during the reset cycle.
    assign DATA_IN_READY = (state_q == S_DATA) && !RESET;
    assign accept        = DATA_IN_VALID && DATA_IN_READY;

    bch_parity_lfsr #(
        .M    (M),
        .POLY (ENC_BCH_POLYNOM)
    ) u_lfsr (
        .CLK        (CLK),
        .RESET      (RESET),
        .clr        (in_parity && (cnt_q == M_LAST)),
        .en         (accept || in_parity),
        .shift_out  (in_parity),
        .shift_in   (DATA_IN),
        .parity_msb (parity_msb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dval_d  = 1'b0;
        if (in_parity) begin
            dout_d = parity_msb;
            dval_d = 1'b1;
            if (cnt_q == M_LAST) begin
                cnt_d   = '0;
                state_d = S_DATA;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (accept) begin
            dout_d = DATA_IN;
            dval_d = 1'b1;
            if (cnt_q == K_LAST) begin
                cnt_d   = '0;
                state_d = S_PARITY;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            dval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dval_q  <= dval_d;
        end
    end

    assign DATA_OUT       = dout_q;
    assign DATA_OUT_VALID = dval_q;

`ifdef BCH_ENC_SOF_EN
    logic sof_q;

    // Data bit 0 of a word is the accept that happens with the counter at zero in S_DATA.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sof_q <= 1'b0;
        end else begin
            sof_q <= accept && (cnt_q == '0);
        end
    end

    assign DATA_OUT_SOF = sof_q;
`else
    // No start-of-codeword flag in this build.
`endif

endmodule

// File: tb/tb_bch_serial_encoder.sv
module tb_bch_serial_encoder;

    localparam int unsigned N = 7;
    localparam int unsigned K = 4;
    localparam int unsigned M = N - K;
    localparam int unsigned G = 'b1011;

    logic CLK = 1'b0;
    logic RESET;
    logic DATA_IN;
    logic DATA_IN_VALID;
    logic DATA_IN_READY;
    logic DATA_OUT;
    logic DATA_OUT_VALID;
`ifdef BCH_ENC_SOF_EN
    logic DATA_OUT_SOF;
`endif

    always #5 CLK = ~CLK;

    bch_serial_encoder dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .DATA_IN        (DATA_IN),
        .DATA_IN_VALID  (DATA_IN_VALID),
        .DATA_IN_READY  (DATA_IN_READY),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID)
`ifdef BCH_ENC_SOF_EN
        ,
        .DATA_OUT_SOF   (DATA_OUT_SOF)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: current partial word, pending parity bits, expected outputs.
    int unsigned w     = 0;
    int unsigned wcnt  = 0;
    bit          pq[$];
    bit          exp_out   = 1'b0;
    bit          exp_valid = 1'b0;
    bit          exp_sof   = 1'b0;
    bit          outq[$];
    bit          check_en  = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Remainder of v(x) divided by g(x), plain long division.
    function automatic int unsigned polymod(input int unsigned v);
        int unsigned r = v;
        for (int i = 31; i >= int'(M); i--) begin
            if (r[i]) r = r ^ (G << (i - M));
        end
        return r & ((32'd1 << M) - 1);
    endfunction

    // Compare process: outputs are checked every cycle, half a period after the edge.
    always @(negedge CLK) begin
        if (check_en) begin
            check("dout_valid", DATA_OUT_VALID, exp_valid);
            check("dout", DATA_OUT, exp_out);
`ifdef BCH_ENC_SOF_EN
            check("sof", DATA_OUT_SOF, exp_sof);
`endif
            if (DATA_OUT_VALID) outq.push_back(DATA_OUT);
        end
    end

    task automatic cycle(input bit r, input bit v, input bit d);
        bit          n_out, n_val, n_sof, ready_exp;
        int unsigned par;
        RESET         = r;
        DATA_IN_VALID = v;
        DATA_IN       = d;
        #1;
        ready_exp = !r && (pq.size() == 0);
        check("ready", DATA_IN_READY, ready_exp);
        n_sof = 1'b0;
        if (r) begin
            w = 0;
            wcnt = 0;
            pq.delete();
            n_out = 1'b0;
            n_val = 1'b0;
        end else if (pq.size() > 0) begin
            n_out = pq.pop_front();
            n_val = 1'b1;
        end else if (v) begin
            n_out = d;
            n_val = 1'b1;
            n_sof = (wcnt == 0);
            w     = (w << 1) | int'(d);
            wcnt++;
            if (wcnt == K) begin
                par = polymod(w << M);
                for (int i = M - 1; i >= 0; i--) pq.push_back(par[i]);
                w    = 0;
                wcnt = 0;
            end
        end else begin
            n_out = exp_out;
            n_val = 1'b0;
        end
        @(posedge CLK);
        exp_out   = n_out;
        exp_valid = n_val;
        exp_sof   = n_sof;
        @(negedge CLK);
        #1;
    endtask

    // Feeds one K-bit word (MSB first) with random 0..maxgap idle cycles before each bit,
    // then collects the N coded bits that come out.
    task automatic run_word(input int unsigned data, input int unsigned maxgap,
                            output int unsigned cw);
        int budget = 0;
        outq.delete();
        for (int b = K - 1; b >= 0; b--) begin
            while (pq.size() > 0) cycle(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            repeat ($urandom_range(maxgap, 0)) cycle(1'b0, 1'b0, 1'($urandom_range(1, 0)));
            cycle(1'b0, 1'b1, data[b]);
        end
        while (outq.size() < N && budget < 20) begin
            cycle(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            budget++;
        end
        check("word_len", outq.size(), N);
        cw = 0;
        foreach (outq[i]) cw = (cw << 1) | int'(outq[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cw, data, rx, s;
        int          j;
        RESET         = 1'b1;
        DATA_IN       = 1'b0;
        DATA_IN_VALID = 1'b0;
        check_en      = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);

        run_word(4'b1000, 0, cw);
        check("w1000", cw, 7'b1000101);
        run_word(4'b0001, 0, cw);
        check("w0001", cw, 7'b0001011);
        run_word(4'b1111, 0, cw);
        check("w1111", cw, 7'b1111111);
        run_word(4'b0000, 3, cw);
        check("w0000_gaps", cw, 7'b0000000);

        // Abort word 1000 after two parity bits have come out.
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        run_word(4'b0001, 0, cw);
        check("w0001_after_reset", cw, 7'b0001011);

        for (int i = 0; i < 1000; i++) begin
            if (i % 97 == 5) begin
                cycle(1'b0, 1'b1, 1'($urandom_range(1, 0)));
                cycle(1'b0, 1'b1, 1'($urandom_range(1, 0)));
                cycle(1'b1, 1'b0, 1'b0);
            end
            data = $urandom_range(15, 0);
            run_word(data, 1, cw);
            check("syndrome", polymod(cw), 0);
            check("dec_clean", cw >> M, data);
            j  = $urandom_range(N - 1, 0);
            rx = cw ^ (32'd1 << j);
            s  = polymod(rx);
            for (int jj = 0; jj < int'(N); jj++) begin
                if (s != 0 && polymod(32'd1 << jj) == s) rx = rx ^ (32'd1 << jj);
            end
            check("dec_flip", rx >> M, data);
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
